// File: rtl/ahb_dma_burst_engine_if.sv
// AHB-Lite master-port bundle between the DMA burst engine (master) and the bus/slave side.
interface ahb_dma_burst_engine_if #(
  parameter int DATA_W = 32
);
  logic              hready_i;
  logic              hresp_i;
  logic [DATA_W-1:0] hrdata_i;
  logic [31:0]       haddr_o;
  logic [1:0]        htrans_o;
  logic              hwrite_o;
  logic [2:0]        hsize_o;
  logic [2:0]        hburst_o;
  logic [DATA_W-1:0] hwdata_o;

  modport master (
    input  hready_i, hresp_i, hrdata_i,
    output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o
  );

  modport slave (
    output hready_i, hresp_i, hrdata_i,
    input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o
  );
endinterface

// File: rtl/ahb_dma_burst_engine.sv
// Single-channel AHB-Lite DMA: INCR read bursts into a beat buffer, then write bursts out.
// Optional feature macro: DMA_ERR_ABORT_EN (abort on error response, sticky err output).
module ahb_dma_burst_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int BURST  = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
`ifdef DMA_ERR_ABORT_EN
  output logic              err,
`endif
  output logic [1:0]        dbg_state,
  input  logic [31:0]       haddr_cpu_i,
  input  logic [1:0]        htrans_cpu_i,
  input  logic              hwrite_cpu_i,
  input  logic [2:0]        hsize_cpu_i,
  input  logic [DATA_W-1:0] hwdata_cpu_i,
  ahb_dma_burst_engine_if.master bus
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_RD      = 2'd1;
  localparam logic [1:0]  S_WR      = 2'd2;
  localparam logic [1:0]  S_FIN     = 2'd3;
  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [1:0]  HT_SEQ    = 2'b11;
  localparam int          CW        = $clog2(BURST + 1);
  localparam int          IW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [31:0] STEP      = 32'(DATA_W / 8);
  localparam logic [2:0]  SIZE      = 3'($clog2(DATA_W / 8));

  logic [1:0]        state;
  logic              fin_wait;   // FIN held one extra busy cycle (zero length, abort)
  logic [31:0]       src_ptr;
  logic [31:0]       dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [CW-1:0]     chunk;
  logic [CW-1:0]     beat;       // address phases accepted in this burst
  logic              pend;       // a data phase is outstanding
  logic [IW-1:0]     dbeat;      // buffer index of the outstanding data phase
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buffer [BURST];

  logic       in_xfer;
  logic       addr_vld;
  logic       accept;
  logic       last_done;
  logic       data_err;
  logic [1:0] eng_trans;

  function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] r);
    if (32'(r) >= 32'(BURST)) chunk_of = CW'(BURST);
    else                      chunk_of = CW'(r);
  endfunction

  // Handshake: an address phase is offered while htrans is NONSEQ/SEQ and is
  // accepted on a rising edge with hready_i=1; the data phase of that beat then
  // runs in the following cycle(s) and completes on the next edge with hready_i=1.
  assign in_xfer   = (state == S_RD) || (state == S_WR);
  assign addr_vld  = in_xfer && (beat < chunk);
  assign accept    = addr_vld && bus.hready_i;
  assign last_done = in_xfer && pend && !addr_vld && bus.hready_i;
  assign eng_trans = addr_vld ? ((beat == '0) ? HT_NONSEQ : HT_SEQ) : HT_IDLE;

`ifdef DMA_ERR_ABORT_EN
  logic err_q;
  assign data_err = in_xfer && pend && bus.hready_i && bus.hresp_i;
  assign err      = err_q;
`else
  logic unused_hresp;
  assign data_err     = 1'b0;
  assign unused_hresp = bus.hresp_i;
`endif

  assign busy      = in_xfer || ((state == S_FIN) && fin_wait);
  assign done      = (state == S_FIN) && !fin_wait;
  assign dbg_state = state;

  always_comb begin
    if (busy) begin
      bus.haddr_o  = (state == S_WR) ? dst_ptr : src_ptr;
      bus.htrans_o = eng_trans;
      bus.hwrite_o = (state == S_WR);
      bus.hsize_o  = SIZE;
      bus.hburst_o = 3'b001;
      bus.hwdata_o = wdata_q;
    end else begin
      bus.haddr_o  = haddr_cpu_i;
      bus.htrans_o = htrans_cpu_i;
      bus.hwrite_o = hwrite_cpu_i;
      bus.hsize_o  = hsize_cpu_i;
      bus.hburst_o = 3'b000;
      bus.hwdata_o = hwdata_cpu_i;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      fin_wait  <= 1'b0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      chunk     <= '0;
      beat      <= '0;
      pend      <= 1'b0;
      dbeat     <= '0;
      wdata_q   <= '0;
`ifdef DMA_ERR_ABORT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
            chunk     <= chunk_of(length);
            beat      <= '0;
            pend      <= 1'b0;
`ifdef DMA_ERR_ABORT_EN
            err_q     <= 1'b0;
`endif
            if (length == '0) begin
              state    <= S_FIN;
              fin_wait <= 1'b1;
            end else begin
              state    <= S_RD;
            end
          end
        end
        S_RD, S_WR: begin
          if (data_err) begin
            state    <= S_FIN;
            fin_wait <= 1'b1;
            pend     <= 1'b0;
`ifdef DMA_ERR_ABORT_EN
            err_q    <= 1'b1;
`endif
          end else if (bus.hready_i) begin
            if (accept) begin
              beat  <= beat + CW'(1);
              dbeat <= beat[IW-1:0];
              pend  <= 1'b1;
              if (state == S_RD) begin
                src_ptr <= src_ptr + STEP;
              end else begin
                dst_ptr <= dst_ptr + STEP;
                wdata_q <= buffer[beat[IW-1:0]];
              end
            end else begin
              pend <= 1'b0;
            end
            if (last_done) begin
              beat <= '0;
              if (state == S_RD) begin
                state <= S_WR;
              end else begin
                remaining <= remaining - LEN_W'(chunk);
                chunk     <= chunk_of(remaining - LEN_W'(chunk));
                state     <= (remaining == LEN_W'(chunk)) ? S_FIN : S_RD;
              end
            end
          end
        end
        S_FIN: begin
          if (fin_wait) fin_wait <= 1'b0;
          else          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data lands only on a completed read data phase; contents are don't-care after reset.
  always_ff @(posedge hclk) begin
    if (!hreset && (state == S_RD) && pend && bus.hready_i) begin
      buffer[dbeat] <= bus.hrdata_i;
    end
  end

endmodule

// File: tb/tb_ahb_dma_burst_engine.sv
// Self-checking bench for ahb_dma_burst_engine: random-stall AHB slave with memory, write scoreboard.
module tb_ahb_dma_burst_engine;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int BURST  = 4;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  logic              start;
  logic [31:0]       src_addr;
  logic [31:0]       dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;
`ifdef DMA_ERR_ABORT_EN
  logic              err;
`endif
  logic [31:0]       haddr_cpu_i;
  logic [1:0]        htrans_cpu_i;
  logic              hwrite_cpu_i;
  logic [2:0]        hsize_cpu_i;
  logic [DATA_W-1:0] hwdata_cpu_i;

  ahb_dma_burst_engine_if #(.DATA_W(DATA_W)) bus ();

  ahb_dma_burst_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BURST(BURST)) dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
`ifdef DMA_ERR_ABORT_EN
    .err          (err),
`endif
    .dbg_state    (dbg_state),
    .haddr_cpu_i  (haddr_cpu_i),
    .htrans_cpu_i (htrans_cpu_i),
    .hwrite_cpu_i (hwrite_cpu_i),
    .hsize_cpu_i  (hsize_cpu_i),
    .hwdata_cpu_i (hwdata_cpu_i),
    .bus          (bus)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- memory model and scoreboard ----------------
  logic [DATA_W-1:0] mem [int unsigned];
  logic [DATA_W-1:0] exp_q[$];
  logic [31:0]       exp_addr_q[$];

  function automatic logic [DATA_W-1:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : DATA_W'(32'hDEAD_BEEF);
  endfunction

  int   stall_pct  = 0;
  bit   sb_on      = 1'b1;
  int   err_beat   = -1;
  int   rd_beats   = 0;
  int   cyc        = 0;
  int   first_ns   = -1;
  int   done_cyc   = -1;
  int   done_cnt   = 0;
  int   nonseq_cnt = 0;
  int   stall_busy = 0;

  bit                pend = 1'b0;
  logic [31:0]       pend_addr;
  bit                pend_wr;
  bit                hr_prev = 1'b1;
  bit                busy_prev = 1'b0;
  bit                pend_wr_prev = 1'b0;
  logic [31:0]       haddr_prev;
  logic [1:0]        htrans_prev;
  logic              hwrite_prev;
  logic [DATA_W-1:0] hwdata_prev;

  // AHB slave + monitor: observes each cycle at the falling edge, decides hready for
  // the coming rising edge, and serves/absorbs the outstanding data phase.
  initial begin
    bus.hready_i = 1'b1;
    bus.hresp_i  = 1'b0;
    bus.hrdata_i = '0;
    forever begin
      bit hr;
      @(negedge hclk);
      cyc++;
      if (hreset) begin
        pend         = 1'b0;
        hr_prev      = 1'b1;
        busy_prev    = 1'b0;
        bus.hready_i = 1'b1;
        bus.hresp_i  = 1'b0;
      end else begin
        hr = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
        if (!hr_prev && busy_prev && busy) begin
          check("hold_haddr",  bus.haddr_o,  haddr_prev);
          check("hold_htrans", bus.htrans_o, htrans_prev);
          check("hold_hwrite", bus.hwrite_o, hwrite_prev);
          if (pend_wr_prev) check("hold_hwdata", bus.hwdata_o, hwdata_prev);
        end
        if (busy && bus.htrans_o == HT_NONSEQ && first_ns < 0) first_ns = cyc;
        if (busy && !hr) stall_busy++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        bus.hresp_i = 1'b0;
        if (pend && !pend_wr) bus.hrdata_i = hr ? mem_rd(pend_addr) : DATA_W'($urandom);
        if (pend && hr) begin
          if (pend_wr) begin
            if (sb_on) begin
              if (exp_q.size() == 0) begin
                check("wr_unexpected_addr", pend_addr, 32'hFFFF_FFFF);
              end else begin
                check("wr_addr", pend_addr, exp_addr_q.pop_front());
                check("wr_data", bus.hwdata_o, exp_q.pop_front());
              end
            end
            mem[pend_addr] = bus.hwdata_o;
          end else begin
            if (rd_beats == err_beat) bus.hresp_i = 1'b1;
            rd_beats++;
          end
        end
        haddr_prev   = bus.haddr_o;
        htrans_prev  = bus.htrans_o;
        hwrite_prev  = bus.hwrite_o;
        hwdata_prev  = bus.hwdata_o;
        busy_prev    = busy;
        hr_prev      = hr;
        pend_wr_prev = pend && pend_wr;
        if (hr) begin
          if (busy && bus.htrans_o[1]) begin
            pend      = 1'b1;
            pend_addr = bus.haddr_o;
            pend_wr   = bus.hwrite_o;
            if (bus.htrans_o == HT_NONSEQ) nonseq_cnt++;
          end else begin
            pend = 1'b0;
          end
        end
        bus.hready_i = hr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int pct, input bit poke);
    int nb;
    int budget;
    int dc0;
    logic [DATA_W-1:0] v;
    nb = (len + BURST - 1) / BURST;
    for (int i = 0; i < len; i++) begin
      v = DATA_W'($urandom);
      mem[src + 32'(4 * i)] = v;
      exp_q.push_back(v);
      exp_addr_q.push_back(dst + 32'(4 * i));
    end
    stall_pct  = pct;
    first_ns   = -1;
    done_cyc   = -1;
    nonseq_cnt = 0;
    stall_busy = 0;
    rd_beats   = 0;
    dc0        = done_cnt;
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    length   = LEN_W'(len);
    @(negedge hclk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    if (poke) begin
      repeat (2) begin @(negedge hclk); #1; end
      start    = 1'b1;
      src_addr = 32'h9000;
      dst_addr = 32'h9800;
      length   = LEN_W'(3);
      @(negedge hclk); #1;
      start = 1'b0;
    end
    budget = 0;
    while (done_cnt == dc0 && budget < 3000) begin
      @(negedge hclk); #1;
      budget++;
    end
    check("done_seen", done_cnt - dc0, 1);
    check("busy_low_at_done", busy, 1'b0);
    stall_pct = 0;
    repeat (4) begin @(negedge hclk); #1; end
    check("done_once", done_cnt - dc0, 1);
    check("wr_queue_drained", exp_q.size(), 0);
    check("nonseq_count", nonseq_cnt, 2 * nb);
    check("done_latency", done_cyc - first_ns, 2 * len + 2 * nb + stall_busy);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc0;
    int nc0;
    int budget;
    hreset       = 1'b1;
    start        = 1'b0;
    src_addr     = '0;
    dst_addr     = '0;
    length       = '0;
    haddr_cpu_i  = 32'h1234_5678;
    htrans_cpu_i = HT_NONSEQ;
    hwrite_cpu_i = 1'b1;
    hsize_cpu_i  = 3'd1;
    hwdata_cpu_i = 32'hCAFE_F00D;
    repeat (3) begin @(negedge hclk); #1; end
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_htrans_mirror", bus.htrans_o, htrans_cpu_i);
`ifdef DMA_ERR_ABORT_EN
    check("rst_err", err, 1'b0);
`endif
    hreset = 1'b0;
    @(negedge hclk); #1;

    for (int i = 0; i < 4; i++) begin
      haddr_cpu_i  = $urandom;
      hwdata_cpu_i = DATA_W'($urandom);
      htrans_cpu_i = 2'($urandom_range(0, 3));
      hwrite_cpu_i = 1'($urandom_range(0, 1));
      hsize_cpu_i  = 3'($urandom_range(0, 2));
      #1;
      check("pass_haddr",  bus.haddr_o,  haddr_cpu_i);
      check("pass_hwdata", bus.hwdata_o, hwdata_cpu_i);
      check("pass_htrans", bus.htrans_o, htrans_cpu_i);
      check("pass_hwrite", bus.hwrite_o, hwrite_cpu_i);
      check("pass_hsize",  bus.hsize_o,  hsize_cpu_i);
      @(negedge hclk); #1;
    end
    haddr_cpu_i  = 32'hC0DE_0000;
    htrans_cpu_i = HT_NONSEQ;

    run_xfer(32'h100, 32'h200, 6, 0, 1'b0);
    run_xfer(32'h100, 32'h200, 6, 35, 1'b0);
    run_xfer(32'h300, 32'h400, 9, 0, 1'b1);
    run_xfer(32'h500, 32'h600, 4, 0, 1'b0);
    run_xfer(32'h700, 32'h800, 1, 20, 1'b0);
    for (int t = 0; t < 6; t++) begin
      run_xfer(32'h1000 + 32'(4 * $urandom_range(0, 200)),
               32'h3000 + 32'(4 * $urandom_range(0, 200)),
               $urandom_range(1, 20), $urandom_range(0, 40), 1'b0);
    end

    // zero length
    dc0 = done_cnt;
    nc0 = nonseq_cnt;
    start    = 1'b1;
    length   = '0;
    src_addr = 32'h100;
    dst_addr = 32'h200;
    @(negedge hclk); #1;
    start = 1'b0;
    check("zl_busy_c1", busy, 1'b1);
    check("zl_done_c1", done, 1'b0);
    check("zl_htrans_idle", bus.htrans_o, HT_IDLE);
    @(negedge hclk); #1;
    check("zl_done_c2", done, 1'b1);
    check("zl_busy_c2", busy, 1'b0);
    @(negedge hclk); #1;
    check("zl_done_c3", done, 1'b0);
    check("zl_no_nonseq", nonseq_cnt - nc0, 0);
    check("zl_done_once", done_cnt - dc0, 1);

    // reset during write beat 2
    sb_on     = 1'b0;
    stall_pct = 0;
    dc0       = done_cnt;
    start    = 1'b1;
    src_addr = 32'h100;
    dst_addr = 32'h200;
    length   = LEN_W'(8);
    @(negedge hclk); #1;
    start  = 1'b0;
    budget = 0;
    while (!(busy && bus.hwrite_o && bus.htrans_o == HT_SEQ && bus.haddr_o == 32'h208)
           && budget < 100) begin
      @(negedge hclk); #1;
      budget++;
    end
    check("rstmid_reached_wr2", budget < 100, 1'b1);
    hreset = 1'b1;
    @(negedge hclk); #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_state", dbg_state, 2'd0);
    check("rstmid_htrans", bus.htrans_o, htrans_cpu_i);
    check("rstmid_haddr", bus.haddr_o, haddr_cpu_i);
    hreset = 1'b0;
    repeat (20) begin @(negedge hclk); #1; end
    check("rstmid_no_done", done_cnt - dc0, 0);
    exp_q.delete();
    exp_addr_q.delete();
    sb_on = 1'b1;

`ifdef DMA_ERR_ABORT_EN
    // error response on read beat 1
    dc0      = done_cnt;
    rd_beats = 0;
    err_beat = 1;
    start    = 1'b1;
    src_addr = 32'h100;
    dst_addr = 32'h200;
    length   = LEN_W'(6);
    @(negedge hclk); #1;
    start  = 1'b0;
    budget = 0;
    while (!err && budget < 50) begin
      @(negedge hclk); #1;
      budget++;
    end
    check("abort_err_set", err, 1'b1);
    check("abort_htrans_idle", bus.htrans_o, HT_IDLE);
    @(negedge hclk); #1;
    check("abort_done", done, 1'b1);
    repeat (5) begin @(negedge hclk); #1; end
    check("abort_err_sticky", err, 1'b1);
    check("abort_done_once", done_cnt - dc0, 1);
    err_beat = -1;
    run_xfer(32'h500, 32'h600, 2, 0, 1'b0);
    check("abort_err_cleared", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
